fetch_align: RTL

- Instruction fetch/realignment unit.
- Produces the instruction stream consumed by the decode stage.
- Fetches word-aligned 32-bit words from instruction memory and buffers them as halfwords.
- Presents one whole instruction per handshake: 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. PC advances by 2 or 4 accordingly.

---
 rtl/fetch_align.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_align.sv
// fetch_align: instruction fetch / realignment unit feeding the decode stage.
// Fetches word-aligned 32-bit words and buffers them as halfwords. It presents
// one whole instruction per handshake, including 32-bit instructions that
// straddle a word boundary.
// Optional feature macro: COMPRESSED_EN. When defined, 16-bit compressed
// instructions are recognised. When undefined, every instruction is 32-bit and
// any PC with bit1 set raises O_misaligned.
// Ports:
//   I_clk, I_rst         clock, asynchronous active-high reset
//   O_memreq, O_memaddr  one-cycle read request, word-aligned address
//   I_memdata, I_memvalid read response (single outstanding request)
//   O_instr, O_pc, O_valid, I_ready  instruction stream handshake to decode
//   I_redirect, I_target new-PC pulse (flushes the buffer)
//   O_misaligned         redirect/reset target not 4-byte aligned (32-bit only mode)
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  output logic        O_memreq,
  output logic [31:0] O_memaddr,
  input  logic [31:0] I_memdata,
  input  logic        I_memvalid,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_valid,
  input  logic        I_ready,
  input  logic        I_redirect,
  input  logic [31:0] I_target,
  output logic        O_misaligned
);

  localparam int unsigned HW_W  = 16;
  localparam int unsigned CNT_W = 3;
  localparam logic [31:0] RST_PC = RESET_PC & ~32'h1;
  localparam logic [31:0] RST_FA = RESET_PC & ~32'h3;
`ifdef COMPRESSED_EN
  localparam logic RST_MIS = 1'b0;
`else
  localparam logic RST_MIS = RESET_PC[1];
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [HW_W-1:0]   hw_q [4];
  logic [HW_W-1:0]   hw_d [4];
  logic [HW_W-1:0]   sh   [4];
  logic [CNT_W-1:0]  cnt_q, cnt_d, rem;
  logic [31:0]       pc_q, pc_d, faddr_q, faddr_d;
  logic              skip_q, skip_d, mis_q, mis_d;
  logic              live_q;
  logic              is32, valid, consume, req, accept;

  // State register
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 4; i++) hw_q[i] <= '0;
      cnt_q   <= '0;
      pc_q    <= RST_PC;
      faddr_q <= RST_FA;
      skip_q  <= RESET_PC[1];
      mis_q   <= RST_MIS;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) hw_q[i] <= hw_d[i];
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      faddr_q <= faddr_d;
      skip_q  <= skip_d;
      mis_q   <= mis_d;
      // Holds off the first fetch until the cycle after reset release
      live_q  <= 1'b1;
    end
  end

  // Next-state: consume, append, request and redirect flush
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    faddr_d = faddr_q;
    skip_d  = skip_q;
    mis_d   = mis_q;
    rem     = cnt_q;
    for (int i = 0; i < 4; i++) begin
      hw_d[i] = hw_q[i];
      sh[i]   = hw_q[i];
    end

`ifdef COMPRESSED_EN
    is32  = (hw_q[0][1:0] == 2'b11);
    valid = is32 ? (cnt_q >= CNT_W'(2)) : (cnt_q >= CNT_W'(1));
`else
    is32  = 1'b1;
    valid = !mis_q && (cnt_q >= CNT_W'(2));
`endif
    consume = valid && I_ready && !I_redirect;
    req     = live_q && !mis_q && (state_q == S_IDLE) &&
              (cnt_q <= CNT_W'(2)) && !I_redirect;
    accept  = (state_q == S_WAIT) && I_memvalid && !I_redirect;

    // Shift out the consumed instruction
    if (consume) begin
      if (is32) begin
        sh   = '{hw_q[2], hw_q[3], HW_W'(0), HW_W'(0)};
        rem  = cnt_q - CNT_W'(2);
        pc_d = pc_q + 32'd4;
      end else begin
        sh   = '{hw_q[1], hw_q[2], hw_q[3], HW_W'(0)};
        rem  = cnt_q - CNT_W'(1);
        pc_d = pc_q + 32'd2;
      end
    end

    // Append the response behind whatever remains after the shift
    for (int i = 0; i < 4; i++) begin
      hw_d[i] = sh[i];
      if (accept) begin
        if (skip_q) begin
          if (CNT_W'(i) == rem) hw_d[i] = I_memdata[31:16];
        end else begin
          if (CNT_W'(i) == rem)            hw_d[i] = I_memdata[15:0];
          if (CNT_W'(i) == rem + CNT_W'(1)) hw_d[i] = I_memdata[31:16];
        end
      end
    end

    if (accept) begin
      cnt_d  = rem + (skip_q ? CNT_W'(1) : CNT_W'(2));
      skip_d = 1'b0;
    end else begin
      cnt_d  = rem;
    end

    if (req) faddr_d = faddr_q + 32'd4;

    case (state_q)
      S_IDLE:  if (req) state_d = S_WAIT;
      S_WAIT:  if (I_memvalid) state_d = S_IDLE;
               else if (I_redirect) state_d = S_DROP;
      S_DROP:  if (I_memvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Redirect flushes the buffer; a response racing it is discarded above
    if (I_redirect) begin
      cnt_d   = '0;
      pc_d    = I_target & ~32'h1;
      faddr_d = I_target & ~32'h3;
      skip_d  = I_target[1];
`ifdef COMPRESSED_EN
      mis_d   = 1'b0;
`else
      mis_d   = I_target[1];
`endif
    end
  end

  assign O_valid      = valid;
  assign O_instr      = is32 ? {hw_q[1], hw_q[0]} : {16'h0000, hw_q[0]};
  assign O_pc         = pc_q;
  assign O_memreq     = req;
  assign O_memaddr    = faddr_q;
  assign O_misaligned = mis_q;

endmodule
